// File: rtl/cpu_exec_controller.sv
// Execution sequencer for the RPN calculator CPU: issues the one-cycle Go strobe
// under run/halt/single-step control, with an IP breakpoint and a saturating instruction counter.
module cpu_exec_controller #(
    parameter int TICK_MAX = 12_500_000,
    parameter int IP_W     = 8,
    parameter int CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Turbo,
    input  logic             RunPb,
    input  logic             HaltPb,
    input  logic             StepPb,
    input  logic             BpEn,
    input  logic [IP_W-1:0]  BpAddr,
    input  logic [IP_W-1:0]  IP,
    output logic             Go,
    output logic             Halted,
    output logic [1:0]       State,
    output logic             BpHit,
    output logic [CNT_W-1:0] InstrCount,
    output logic             CountOvf
);

    localparam int TICK_W = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STEP  = 2'b10,
        BREAK = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic                go_q, go_d;
    logic                gap_q, gap_d;
    logic                skip_bp_q, skip_bp_d;
    logic                halted_q, halted_d;
    logic                bp_hit_q, bp_hit_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;

    logic                tick;
    logic                want;
    logic                bp_match;

    always_comb begin
        tick       = (tick_cnt_q == TICK_W'(TICK_MAX));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        want       = (Turbo | tick) & ~gap_q;
        // skip_bp lets the instruction that caused the break execute once on resume
        bp_match   = BpEn && (IP == BpAddr) && !skip_bp_q;

        state_d   = state_q;
        go_d      = 1'b0;
        skip_bp_d = skip_bp_q;

        case (state_q)
            IDLE: begin
                if (HaltPb) begin
                    state_d = IDLE;
                end else if (RunPb) begin
                    state_d = RUN;
                end else if (StepPb) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (HaltPb) begin
                    state_d = IDLE;
                end else if (want) begin
                    if (bp_match) begin
                        state_d = BREAK;
                    end else begin
                        go_d      = 1'b1;
                        skip_bp_d = 1'b0;
                    end
                end
            end
            BREAK: begin
                if (HaltPb) begin
                    state_d = IDLE;
                end else if (RunPb) begin
                    state_d   = RUN;
                    skip_bp_d = 1'b1;
                end else if (StepPb) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (!gap_q) begin
                    go_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Go is never issued back to back so IP settles before the next compare
        gap_d    = go_d;
        halted_d = (state_d != RUN);
        bp_hit_d = (state_d == BREAK);

        count_d = count_q;
        if (go_q && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
        ovf_d = ovf_q | (&count_d);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            go_q       <= 1'b0;
            gap_q      <= 1'b0;
            skip_bp_q  <= 1'b0;
            halted_q   <= 1'b1;
            bp_hit_q   <= 1'b0;
            tick_cnt_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            go_q       <= go_d;
            gap_q      <= gap_d;
            skip_bp_q  <= skip_bp_d;
            halted_q   <= halted_d;
            bp_hit_q   <= bp_hit_d;
            tick_cnt_q <= tick_cnt_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Go         = go_q;
    assign Halted     = halted_q;
    assign State      = state_q;
    assign BpHit      = bp_hit_q;
    assign InstrCount = count_q;
    assign CountOvf   = ovf_q;

endmodule

// File: tb/tb_cpu_exec_controller.sv
// Scoreboard bench for cpu_exec_controller: a small CPU model advances IP on each Go,
// expected IPs per Go are queued by each scenario and compared with the observed Go log.
module tb_cpu_exec_controller;

    logic       Clock = 1'b0;
    logic       Reset, Turbo, RunPb, HaltPb, StepPb, BpEn;
    logic [7:0] BpAddr;
    logic [7:0] IP;
    logic       Go, Halted, BpHit, CountOvf;
    logic [1:0] State;
    logic [3:0] InstrCount;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int go_total = 0;
    int ip_base = 0;
    int ip_ref = 0;
    bit ip_auto = 1'b0;
    int obs_cyc[$];
    int obs_ip[$];
    int exp_ip[$];

    always #5 Clock = ~Clock;

    cpu_exec_controller #(.TICK_MAX(4), .IP_W(8), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .Turbo(Turbo), .RunPb(RunPb), .HaltPb(HaltPb),
        .StepPb(StepPb), .BpEn(BpEn), .BpAddr(BpAddr), .IP(IP), .Go(Go),
        .Halted(Halted), .State(State), .BpHit(BpHit), .InstrCount(InstrCount),
        .CountOvf(CountOvf)
    );

    // CPU model: IP advances by one after each executed instruction
    assign IP = ip_auto ? 8'(ip_base + (go_total - ip_ref)) : 8'(ip_base);

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (Go === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_ip.push_back(int'(IP));
            $display("go: cycle %0d ip %0h count %0d", cyc, IP, InstrCount);
            go_total = go_total + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic clear_sb();
        obs_cyc.delete();
        obs_ip.delete();
        exp_ip.delete();
    endtask

    task automatic set_ip(input int base, input bit auto_inc);
        ip_base = base;
        ip_ref  = go_total;
        ip_auto = auto_inc;
    endtask

    task automatic pulse(input bit r, input bit h, input bit s);
        RunPb = r; HaltPb = h; StepPb = s;
        step(1);
        RunPb = 1'b0; HaltPb = 1'b0; StepPb = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1; RunPb = 1'b0; HaltPb = 1'b0; StepPb = 1'b0;
        step(2);
        Reset = 1'b0;
        step(1);
    endtask

    task automatic wait_go(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_ip.size() >= n) begin
                ok = 1'b1;
                return;
            end
            step(1);
        end
        if (obs_ip.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Turbo = 1'b1; RunPb = 1'b0; HaltPb = 1'b0; StepPb = 1'b0;
        BpEn = 1'b0; BpAddr = 8'h00;
        set_ip(0, 1'b0);
        step(3);
        checks++; if (Go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b expected 0", Go); end
        checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b expected 1", Halted); end
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", State); end
        checks++; if (BpHit !== 1'b0) begin errors++; $display("FAIL reset_bphit: got %b expected 0", BpHit); end
        checks++; if (InstrCount !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", InstrCount); end
        checks++; if (CountOvf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", CountOvf); end
        Reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_slow_run();
        bit ok;
        int e, o;
        do_reset();
        Turbo = 1'b0; BpEn = 1'b0;
        set_ip(0, 1'b1);
        clear_sb();
        for (int i = 0; i < 4; i++) exp_ip.push_back(i);
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (State !== 2'b01 || Halted !== 1'b0) begin errors++; $display("FAIL slow_enter_run: state %b halted %b expected 01/0", State, Halted); end
        wait_go(4, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL slow_go_timeout: got %0d pulses expected 4", obs_ip.size()); end
        checks++; if (InstrCount !== 4'd4) begin errors++; $display("FAIL slow_count: got %0d expected 4", InstrCount); end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] != 5) begin errors++; $display("FAIL slow_period: got %0d expected 5", obs_cyc[i] - obs_cyc[i-1]); end
        end
        while (exp_ip.size() > 0 && obs_ip.size() > 0) begin
            e = exp_ip.pop_front(); o = obs_ip.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL slow_ip: got %0h expected %0h", o, e); end
        end
        clear_sb();
        pulse(1'b0, 1'b1, 1'b0);
        step(12);
        checks++; if (obs_ip.size() != 0) begin errors++; $display("FAIL halt_no_go: got %0d pulses expected 0", obs_ip.size()); end
        checks++; if (Halted !== 1'b1 || State !== 2'b00) begin errors++; $display("FAIL halt_state: state %b halted %b expected 00/1", State, Halted); end
        checks++; if (InstrCount !== 4'd4) begin errors++; $display("FAIL halt_count: got %0d expected 4", InstrCount); end
        $display("test_slow_run done");
    endtask

    task automatic test_turbo();
        int e, o;
        do_reset();
        Turbo = 1'b1; BpEn = 1'b0;
        set_ip(0, 1'b1);
        clear_sb();
        for (int i = 0; i < 5; i++) exp_ip.push_back(i);
        pulse(1'b1, 1'b0, 1'b0);
        step(10);
        checks++; if (obs_ip.size() != 5) begin errors++; $display("FAIL turbo_pulses: got %0d expected 5", obs_ip.size()); end
        checks++; if (InstrCount !== 4'd5) begin errors++; $display("FAIL turbo_count: got %0d expected 5", InstrCount); end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] != 2) begin errors++; $display("FAIL turbo_spacing: got %0d expected 2", obs_cyc[i] - obs_cyc[i-1]); end
        end
        while (exp_ip.size() > 0 && obs_ip.size() > 0) begin
            e = exp_ip.pop_front(); o = obs_ip.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL turbo_ip: got %0h expected %0h", o, e); end
        end
        pulse(1'b0, 1'b1, 1'b0);
        $display("test_turbo done");
    endtask

    task automatic test_breakpoint();
        bit ok;
        int e, o;
        do_reset();
        Turbo = 1'b1; BpEn = 1'b1; BpAddr = 8'h03;
        set_ip(0, 1'b1);
        clear_sb();
        for (int i = 0; i < 3; i++) exp_ip.push_back(i);
        pulse(1'b1, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (State === 2'b11) ok = 1'b1; else step(1);
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: state %b expected 11", State); end
        checks++; if (BpHit !== 1'b1 || Halted !== 1'b1) begin errors++; $display("FAIL bp_flags: bphit %b halted %b expected 1/1", BpHit, Halted); end
        checks++; if (IP !== 8'h03) begin errors++; $display("FAIL bp_ip: got %0h expected 03", IP); end
        checks++; if (InstrCount !== 4'd3) begin errors++; $display("FAIL bp_count: got %0d expected 3", InstrCount); end
        step(4);
        checks++; if (obs_ip.size() != 3) begin errors++; $display("FAIL bp_suppress: got %0d pulses expected 3", obs_ip.size()); end
        while (exp_ip.size() > 0 && obs_ip.size() > 0) begin
            e = exp_ip.pop_front(); o = obs_ip.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL bp_pre_ip: got %0h expected %0h", o, e); end
        end
        clear_sb();
        for (int i = 3; i < 6; i++) exp_ip.push_back(i);
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (BpHit !== 1'b0 || State !== 2'b01) begin errors++; $display("FAIL bp_resume: bphit %b state %b expected 0/01", BpHit, State); end
        step(6);
        checks++; if (obs_ip.size() != 3) begin errors++; $display("FAIL bp_resume_pulses: got %0d expected 3", obs_ip.size()); end
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL bp_no_rebreak: got %b expected 01", State); end
        while (exp_ip.size() > 0 && obs_ip.size() > 0) begin
            e = exp_ip.pop_front(); o = obs_ip.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL bp_post_ip: got %0h expected %0h", o, e); end
        end
        pulse(1'b0, 1'b1, 1'b0);
        BpEn = 1'b0;
        $display("test_breakpoint done");
    endtask

    task automatic test_step();
        int e, o;
        do_reset();
        Turbo = 1'b0; BpEn = 1'b0;
        set_ip(5, 1'b0);
        clear_sb();
        exp_ip.push_back(5);
        StepPb = 1'b1;
        step(1);
        checks++; if (State !== 2'b10) begin errors++; $display("FAIL step_enter: got %b expected 10", State); end
        step(1);
        StepPb = 1'b0;
        checks++; if (Go !== 1'b1) begin errors++; $display("FAIL step_go: got %b expected 1", Go); end
        step(4);
        checks++; if (obs_ip.size() != 1) begin errors++; $display("FAIL step_single: got %0d pulses expected 1", obs_ip.size()); end
        checks++; if (InstrCount !== 4'd1) begin errors++; $display("FAIL step_count: got %0d expected 1", InstrCount); end
        checks++; if (State !== 2'b00 || Halted !== 1'b1) begin errors++; $display("FAIL step_return: state %b halted %b expected 00/1", State, Halted); end
        while (exp_ip.size() > 0 && obs_ip.size() > 0) begin
            e = exp_ip.pop_front(); o = obs_ip.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL step_ip: got %0h expected %0h", o, e); end
        end
        $display("test_step done");
    endtask

    task automatic test_priority();
        do_reset();
        Turbo = 1'b0;
        pulse(1'b1, 1'b0, 1'b1);
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL prio_run_over_step: got %b expected 01", State); end
        pulse(1'b1, 1'b1, 1'b0);
        checks++; if (State !== 2'b00 || Halted !== 1'b1) begin errors++; $display("FAIL prio_halt_over_run: state %b halted %b expected 00/1", State, Halted); end
        $display("test_priority done");
    endtask

    task automatic test_overflow();
        bit ok;
        int e, o;
        do_reset();
        Turbo = 1'b1; BpEn = 1'b0;
        set_ip(0, 1'b1);
        clear_sb();
        for (int i = 0; i < 16; i++) exp_ip.push_back(i);
        pulse(1'b1, 1'b0, 1'b0);
        wait_go(14, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout14: got %0d pulses expected 14", obs_ip.size()); end
        checks++; if (InstrCount !== 4'd14 || CountOvf !== 1'b0) begin errors++; $display("FAIL ovf_pre: count %0d ovf %b expected 14/0", InstrCount, CountOvf); end
        wait_go(15, 10, ok);
        checks++; if (InstrCount !== 4'hF || CountOvf !== 1'b1) begin errors++; $display("FAIL ovf_sat: count %0d ovf %b expected 15/1", InstrCount, CountOvf); end
        wait_go(16, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout16: got %0d pulses expected 16", obs_ip.size()); end
        checks++; if (InstrCount !== 4'hF || CountOvf !== 1'b1) begin errors++; $display("FAIL ovf_hold: count %0d ovf %b expected 15/1", InstrCount, CountOvf); end
        while (exp_ip.size() > 0 && obs_ip.size() > 0) begin
            e = exp_ip.pop_front(); o = obs_ip.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL ovf_ip: got %0h expected %0h", o, e); end
        end
        Reset = 1'b1;
        step(1);
        checks++; if (Go !== 1'b0) begin errors++; $display("FAIL reset_midrun_go: got %b expected 0", Go); end
        checks++; if (InstrCount !== 4'd0 || CountOvf !== 1'b0) begin errors++; $display("FAIL reset_midrun_count: count %0d ovf %b expected 0/0", InstrCount, CountOvf); end
        checks++; if (State !== 2'b00 || Halted !== 1'b1) begin errors++; $display("FAIL reset_midrun_state: state %b halted %b expected 00/1", State, Halted); end
        Reset = 1'b0;
        $display("test_overflow done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_slow_run();
        test_turbo();
        test_breakpoint();
        test_step();
        test_priority();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_exec_controller.md
Name: cpu_exec_controller

Overview:
Execution sequencer for the RPN calculator CPU. It generates the single-cycle `Go` strobe that advances the CPU instruction cycle, replacing the free-running tick/turbo logic. It adds run/halt/single-step control, an IP breakpoint and an executed-instruction counter. It sits between the board controls (already synchronised and edge-detected) and the CPU's go input, and observes the CPU's IP.

Parameters:
TICK_MAX, 12_500_000, slow-mode tick counter wraps at this value; slow Go period is TICK_MAX+1 cycles
IP_W, 8, width of IP and BpAddr
CNT_W, 16, width of instruction counter

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Turbo  in  1  synchronised level; 1 = issue Go as fast as allowed
RunPb  in  1  single-cycle pulse: start/resume running
HaltPb  in  1  single-cycle pulse: stop running
StepPb  in  1  single-cycle pulse: execute exactly one instruction
BpEn  in  1  breakpoint enable
BpAddr  in  IP_W  breakpoint instruction address
IP  in  IP_W  current CPU instruction pointer
Go  out  1  registered, one-cycle execute strobe to CPU
Halted  out  1  registered; 1 when state != RUN
State  out  2  registered FSM state encoding
BpHit  out  1  registered; 1 while in BREAK
InstrCount  out  CNT_W  number of Go pulses issued, saturating
CountOvf  out  1  sticky; set when InstrCount saturates

Behaviour:
- Reset (synchronous, overrides everything in the same cycle): state=IDLE, Go=0, Halted=1, BpHit=0, InstrCount=0, CountOvf=0, tick counter=0, gap flag=0, skip_bp=0.
- State encodings: IDLE=2'b00, RUN=2'b01, STEP=2'b10, BREAK=2'b11.
- Tick counter: free-running 0..TICK_MAX, then wraps to 0. tick=1 in the cycle where cnt==TICK_MAX. The counter runs in every state.
- Go spacing: after any cycle with Go=1, Go is forced 0 for the next cycle. Go is never high on two consecutive cycles, so IP has settled before the breakpoint compare. With Turbo, Go toggles on alternate cycles.
- Issue condition in RUN: want = (Turbo | tick) & !gap.
- RUN, want=1, BpEn=1, IP==BpAddr, skip_bp=0: Go stays 0; next state is BREAK and BpHit becomes 1.
- RUN, want=1, otherwise: Go=1 next cycle; skip_bp cleared.
- Transitions, evaluated only on pulses; priority is Halt > Run > Step:
  - IDLE: RunPb goes to RUN; StepPb goes to STEP.
  - RUN: HaltPb goes to IDLE, and a pending Go is not issued. RunPb and StepPb are ignored.
  - BREAK: RunPb goes to RUN with skip_bp=1, so the breakpointed instruction executes once. StepPb goes to STEP. HaltPb goes to IDLE. BpHit clears on leaving BREAK.
  - STEP: on the first cycle with gap=0, Go=1 (no tick wait, breakpoint ignored), then return to IDLE. All pulses are ignored while in STEP.
- Halted and State update in the same cycle as the state register.
- InstrCount: +1 on each cycle with Go=1. At all-ones it holds, and CountOvf is set and stays set until Reset.
- Changing BpAddr or BpEn takes effect on the next issue decision.
- Reset mid-RUN: the Go in flight is dropped; Go=0 in the cycle after Reset is sampled.

Test Plan:
- TICK_MAX=4, Turbo=0. Reset, then RunPb: Go pulses exactly every 5 cycles and InstrCount increments by 1 per pulse. HaltPb: no further Go, Halted=1, State=00.
- Turbo=1 in RUN: Go pattern 1,0,1,0…; after 10 cycles InstrCount=5.
- BpEn=1, BpAddr=8'h03, IP stepped 0→3 by the model: Go is suppressed at IP=3, State=11, BpHit=1. RunPb: exactly one Go at IP=3 without re-breaking, then normal running.
- In IDLE, StepPb: a single Go within 2 cycles, InstrCount=1, State returns to 00. A StepPb issued during STEP produces no extra Go.
- Same-cycle RunPb+HaltPb in RUN: state goes to IDLE. Same-cycle RunPb+StepPb in IDLE: state goes to RUN.
- CNT_W=4, Turbo=1: after 15 Go pulses InstrCount=4'hF and CountOvf=1. A 16th Go leaves the count at F. Reset clears both.
